padded_window_fetch: RTL
========================

Name: padded_window_fetch

Overview:
- Reads the padded feature map that the padding-write controller places in the activation buffer.
- Streams it to the convolution datapath in kernel-window order, one PE-channel word per beat.
- Generates buffer read addresses for every output pixel, channel group and kernel tap, and absorbs the buffer's fixed 1-cycle read latency with a 2-entry skid buffer under valid/ready backpressure.

Parameters:
PE, 16, channels per word (word = PE*8 bits)
IFM_C, 192, input channels; multiple of PE
IFM_W, 28, unpadded width
IFM_H, 28, unpadded height
PADDING, 1, border width already present in the buffer
K, 3, square kernel size
STRIDE, 1, window stride
ADDR_STEP, 4, buffer address increment per word
BASE_ADDR, 0, buffer address of padded pixel (0,0), channel group 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
rd_en  out  1  buffer read strobe
rd_addr  out  16  buffer read address
rd_data  in  PE*8  buffer data, valid exactly 1 cycle after rd_en
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts the beat when out_valid & out_ready
out_data  out  PE*8  PE channels of one tap
out_last_win  out  1  beat is tap (K-1,K-1) of the current window/channel group
out_last  out  1  final beat of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Derived constants:
  - PW = IFM_W+2*PADDING, PH = IFM_H+2*PADDING
  - CG = IFM_C/PE
  - OFM_W = (PW-K)/STRIDE+1, OFM_H = (PH-K)/STRIDE+1 (integer floor)
  - BEATS = OFM_H*OFM_W*CG*K*K
- Loop order, innermost first: kx, ky, cg, ox, oy.
- Address: rd_addr = BASE_ADDR + (((oy*STRIDE+ky)*PW + ox*STRIDE+kx)*CG + cg)*ADDR_STEP, truncated to 16 bits. It may be computed incrementally, but must equal this formula every beat.
- Reset: state IDLE; counters 0; rd_en=0, rd_addr=0, out_valid=0, out_last_win=0, out_last=0, busy=0, done=0. out_data is don't-care while out_valid=0.
- FSM:
  - IDLE -> ISSUE on start; busy=1 from the next cycle.
  - ISSUE: rd_en=1 only when (skid occupancy + reads in flight) < 2. The counters advance on each issued read. On issuing the final tap -> DRAIN.
  - DRAIN: no reads; waits until the skid buffer is empty and the last beat is accepted -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Read latency:
  - rd_data is captured into the skid buffer on the cycle after rd_en.
  - out_last_win and out_last are tagged at issue and travel with the data.
- Handshake:
  - out_data, out_last_win and out_last stay stable while out_valid=1 and out_ready=0.
  - No beat is dropped or duplicated; beats leave in issue order.
- Throughput: with out_ready held at 1, one beat per cycle after a 2-cycle start-up (start -> first rd_en at +1, first out_valid at +2).
- Boundaries:
  - start while busy is ignored.
  - start in the same cycle as done is ignored; a new start is accepted from the following IDLE cycle.
  - out_ready low for any duration stalls issue once credits are exhausted; counters hold.
  - Issue and skid-buffer pop in the same cycle are allowed when occupancy is 2 and out_ready=1.
  - rst_n asserted mid-frame aborts immediately to the reset values; the in-flight read is discarded.
  - Windows never leave the padded map: ox*STRIDE+K-1 <= PW-1 holds by construction of OFM_W (same for height).

Decomposition:
- Package padded_fetch_pkg: FSM state enum (IDLE, ISSUE, DRAIN, DONE) and localparam functions for PW, PH, CG, OFM_W, OFM_H, BEATS. The padding-write controller reuses the same padded-geometry constants.
- One sub-module: fetch_skid_buf. It is a 2-entry FIFO of {data, last_win, last} that exposes occupancy for the credit check.

Test Plan:
- Config PE=16, IFM_C=32, IFM_W=IFM_H=4, PADDING=1, K=3, STRIDE=1, out_ready=1 -> 288 beats.
  - First 9 rd_addr: 0, 8, 16, 48, 56, 64, 96, 104, 112.
  - Beat 10 address 4 (cg=1).
  - out_last_win on every 9th beat; out_last on beat 288; done one cycle after it.
- Same config, STRIDE=2 -> OFM 2x2, 72 beats; window (oy=0, ox=1) tap (0,0) address (2*2)*4=16.
- Buffer model returns data=address; out_ready random 50% -> out_data sequence equals the ideal address sequence with no loss or duplication, and data stays stable while stalled.
- out_ready held 0 for 20 cycles at beat 5 -> at most 2 beats buffered, rd_en low after credits run out; resumes one beat per cycle on release.
- start pulsed at beat 40 -> ignored, frame still totals 288.
- rst_n low at beat 100 -> outputs at reset values that cycle; the next start restarts at address BASE_ADDR.

Source files
------------

// File: rtl/padded_fetch_pkg.sv
// Shared padded-geometry helpers and fetch FSM state for the activation-buffer
// window fetch path (also used by the padding-write controller).
package padded_fetch_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  function automatic int unsigned calc_pw(input int unsigned ifm_w, input int unsigned padding);
    return ifm_w + 2 * padding;
  endfunction

  function automatic int unsigned calc_ph(input int unsigned ifm_h, input int unsigned padding);
    return ifm_h + 2 * padding;
  endfunction

  function automatic int unsigned calc_cg(input int unsigned ifm_c, input int unsigned pe);
    return ifm_c / pe;
  endfunction

  // Output extent along one axis of the padded map (integer floor).
  function automatic int unsigned calc_ofm(input int unsigned padded, input int unsigned k,
                                           input int unsigned stride);
    return (padded - k) / stride + 1;
  endfunction

  function automatic int unsigned calc_beats(input int unsigned ofm_h, input int unsigned ofm_w,
                                             input int unsigned cg, input int unsigned k);
    return ofm_h * ofm_w * cg * k * k;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/padded_window_fetch_skid.sv
// Two-entry FIFO holding returned buffer words until the consumer takes them;
// occupancy is exported so the issuer can keep reads within its credit.
module fetch_skid_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/padded_window_fetch.sv
// Streams the padded feature map from the activation buffer in kernel-window
// order (kx, ky, cg, ox, oy innermost first), one PE-channel word per beat.
module padded_window_fetch
  import padded_fetch_pkg::*;
#(
  parameter int unsigned PE        = 16,
  parameter int unsigned IFM_C     = 192,
  parameter int unsigned IFM_W     = 28,
  parameter int unsigned IFM_H     = 28,
  parameter int unsigned PADDING   = 1,
  parameter int unsigned K         = 3,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PE*8-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PE*8-1:0]   out_data,
  output logic              out_last_win,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW  = PE * 8;
  localparam int unsigned PW  = calc_pw(IFM_W, PADDING);
  localparam int unsigned PH  = calc_ph(IFM_H, PADDING);
  localparam int unsigned CG  = calc_cg(IFM_C, PE);
  localparam int unsigned OW  = calc_ofm(PW, K, STRIDE);
  localparam int unsigned OH  = calc_ofm(PH, K, STRIDE);
  localparam int unsigned KW  = cnt_w(K);
  localparam int unsigned CGW = cnt_w(CG);
  localparam int unsigned OXW = cnt_w(OW);
  localparam int unsigned OYW = cnt_w(OH);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [KW-1:0]  kx;
  logic [KW-1:0]  ky;
  logic [CGW-1:0] cg;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;

  logic        issue;
  logic        frame_start;
  logic        accept;
  logic        tap_last_win;
  logic        tap_last;
  logic [1:0]  stored_nxt;

  logic        inflight;
  logic        inflight_last_win;
  logic        inflight_last;

  logic          skid_push;
  logic          skid_pop;
  logic [1:0]    skid_count;
  logic [DW+1:0] skid_dout;

  assign tap_last_win = (kx == KW'(K - 1)) && (ky == KW'(K - 1));
  assign tap_last     = tap_last_win && (cg == CGW'(CG - 1)) &&
                        (ox == OXW'(OW - 1)) && (oy == OYW'(OH - 1));

  // A beat is presentable from the skid head, or straight off the buffer
  // port in the cycle its read returns when nothing older is queued.
  assign out_valid = (skid_count != 2'd0) || inflight;
  assign accept    = out_valid && out_ready;

  // Words still held after this cycle; a new read may go out only if its
  // return is guaranteed a skid slot.
  assign stored_nxt = skid_count + 2'(inflight) - 2'(accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (stored_nxt < 2'd2) begin
          issue = 1'b1;
          if (tap_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && out_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  // Window/tap counters, kx fastest; all wrap to zero after the final tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
      cg <= '0;
      ox <= '0;
      oy <= '0;
    end else if (frame_start) begin
      kx <= '0;
      ky <= '0;
      cg <= '0;
      ox <= '0;
      oy <= '0;
    end else if (issue) begin
      if (kx == KW'(K - 1)) begin
        kx <= '0;
        if (ky == KW'(K - 1)) begin
          ky <= '0;
          if (cg == CGW'(CG - 1)) begin
            cg <= '0;
            if (ox == OXW'(OW - 1)) begin
              ox <= '0;
              oy <= (oy == OYW'(OH - 1)) ? '0 : oy + OYW'(1);
            end else begin
              ox <= ox + OXW'(1);
            end
          end else begin
            cg <= cg + CGW'(1);
          end
        end else begin
          ky <= ky + KW'(1);
        end
      end else begin
        kx <= kx + KW'(1);
      end
    end
  end

  assign rd_en   = issue;
  assign rd_addr = issue ?
    ADDR_W'(BASE_ADDR + (((32'(oy) * STRIDE + 32'(ky)) * PW + 32'(ox) * STRIDE + 32'(kx)) * CG
                         + 32'(cg)) * ADDR_STEP) :
    '0;

  // Beat tags ride alongside the read so they meet their data on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight          <= 1'b0;
      inflight_last_win <= 1'b0;
      inflight_last     <= 1'b0;
    end else begin
      inflight          <= issue;
      inflight_last_win <= issue && tap_last_win;
      inflight_last     <= issue && tap_last;
    end
  end

  assign skid_push = inflight && !((skid_count == 2'd0) && out_ready);
  assign skid_pop  = (skid_count != 2'd0) && out_ready;

  fetch_skid_buf #(
    .DW (DW + 2)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (skid_push),
    .din   ({rd_data, inflight_last_win, inflight_last}),
    .pop   (skid_pop),
    .dout  (skid_dout),
    .count (skid_count)
  );

  always_comb begin
    out_data     = '0;
    out_last_win = 1'b0;
    out_last     = 1'b0;
    if (skid_count != 2'd0) begin
      {out_data, out_last_win, out_last} = skid_dout;
    end else if (inflight) begin
      out_data     = rd_data;
      out_last_win = inflight_last_win;
      out_last     = inflight_last;
    end
  end

endmodule
